dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the core load/store unit (c_*) and the DMA engine (d_*).

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Serialises core LSU (c_*) and DMA (d_*) accesses onto the single data-memory port.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise the core always wins ties.
module dmem_arbiter #(
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_sign_mask,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sign_mask,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    output logic        busy
);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_t;

    state_t           state, state_next;
    owner_t           owner;
    logic             owner_we;
    logic [CNT_W-1:0] count;
    logic             pick_dma, sel_we, done;
`ifdef DMEM_ARB_RR_EN
    owner_t           last_owner;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_next = state;
        done       = 1'b0;
        pick_dma   = d_req && !c_req;
`ifdef DMEM_ARB_RR_EN
        if (c_req && d_req) pick_dma = (last_owner == OWN_CORE);
`endif
        sel_we = pick_dma ? d_we : c_we;
        unique case (state)
            IDLE:  if (c_req || d_req) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (count == '0) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= OWN_CORE;
            owner_we       <= 1'b0;
            count          <= '0;
            busy           <= 1'b0;
            c_gnt          <= 1'b0;
            d_gnt          <= 1'b0;
            c_rvalid       <= 1'b0;
            d_rvalid       <= 1'b0;
            c_rdata        <= '0;
            d_rdata        <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_owner     <= OWN_DMA;
`endif
        end else begin
            state        <= state_next;
            busy         <= (state_next != IDLE);
            c_gnt        <= 1'b0;
            d_gnt        <= 1'b0;
            c_rvalid     <= 1'b0;
            d_rvalid     <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;

            // Payload and strobes are registered on acceptance so they are visible in ISSUE.
            if (state == IDLE && state_next == ISSUE) begin
                owner          <= pick_dma ? OWN_DMA : OWN_CORE;
                owner_we       <= sel_we;
                mem_addr       <= pick_dma ? d_addr : c_addr;
                mem_write_data <= pick_dma ? d_wdata : c_wdata;
                mem_sign_mask  <= pick_dma ? d_sign_mask : c_sign_mask;
                mem_memread    <= !sel_we;
                mem_memwrite   <= sel_we;
                c_gnt          <= !pick_dma;
                d_gnt          <= pick_dma;
            end

            if (state == ISSUE) begin
                count <= owner_we ? WR_LOAD : RD_LOAD;
`ifdef DMEM_ARB_RR_EN
                last_owner <= owner;
`endif
            end

            if (state == WAIT && count != '0) count <= count - CNT_W'(1);

            if (done && !owner_we) begin
                if (owner == OWN_DMA) begin
                    d_rdata  <= mem_read_data;
                    d_rvalid <= 1'b1;
                end else begin
                    c_rdata  <= mem_read_data;
                    c_rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-timeline model, data_mem stand-in,
// directed scenarios with literal expectations, then randomized two-requester traffic.
module tb_dmem_arbiter;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  c_sign_mask = 0, d_sign_mask = 0;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 0;
    logic        busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_sign_mask(c_sign_mask),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sign_mask(d_sign_mask),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // data_mem stand-in: read data is valid only in the cycle RD_LAT after the strobe, garbage otherwise.
    logic [31:0] env_mem [logic [31:0]];
    int          env_rd_cyc = -1;
    logic [31:0] env_rd_val = 0;

    always @(posedge clk) begin
        #1;
        mem_read_data = (cyc == env_rd_cyc) ? env_rd_val : $urandom;
    end

    // Reference model: one access described by its start cycle; everything else is arithmetic on it.
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_have = 0, m_dma = 0, m_we = 0, m_last_dma = 1;
    int          m_start = 0, m_lat = 1;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdval = 0, m_c_rdata = 0, m_d_rdata = 0;
    logic [3:0]  m_mask = 0;

    always @(negedge clk) begin : model_blk
        int  c;
        bit  active, issue, ret, idle, win_dma;
        c = cyc;
        if (!rst_n) begin
            m_have = 0; m_last_dma = 1; m_c_rdata = 0; m_d_rdata = 0; env_rd_cyc = -1;
            check("rst_busy", busy, 0);
            check("rst_gnt", {c_gnt, d_gnt}, 0);
            check("rst_rvalid", {c_rvalid, d_rvalid}, 0);
            check("rst_strobe", {mem_memread, mem_memwrite}, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_c_rdata", c_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
        end else begin
            active = m_have && c >= m_start && c <= m_start + m_lat;
            issue  = m_have && c == m_start;
            ret    = m_have && !m_we && c == m_start + m_lat + 1;
            idle   = !m_have || c >= m_start + m_lat + 1;
            if (ret) begin
                if (m_dma) m_d_rdata = m_rdval;
                else       m_c_rdata = m_rdval;
            end
            check("busy", busy, active);
            check("c_gnt", c_gnt, issue && !m_dma);
            check("d_gnt", d_gnt, issue && m_dma);
            check("mem_memread", mem_memread, issue && !m_we);
            check("mem_memwrite", mem_memwrite, issue && m_we);
            if (active) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_sign_mask", mem_sign_mask, m_mask);
                if (m_we) check("mem_write_data", mem_write_data, m_wdata);
            end
            check("c_rvalid", c_rvalid, ret && !m_dma);
            check("d_rvalid", d_rvalid, ret && m_dma);
            check("c_rdata", c_rdata, m_c_rdata);
            check("d_rdata", d_rdata, m_d_rdata);

            if (mem_memread) begin
                env_rd_cyc = c + RD_LAT;
                env_rd_val = env_mem.exists(mem_addr) ? env_mem[mem_addr] : 32'h0;
            end
            if (mem_memwrite) env_mem[mem_addr] = mem_write_data;

            if (idle && (c_req || d_req)) begin
`ifdef DMEM_ARB_RR_EN
                win_dma = (c_req && d_req) ? !m_last_dma : d_req;
`else
                win_dma = !c_req;
`endif
                m_have = 1; m_start = c + 1; m_dma = win_dma; m_last_dma = win_dma;
                m_we    = win_dma ? d_we : c_we;
                m_addr  = win_dma ? d_addr : c_addr;
                m_wdata = win_dma ? d_wdata : c_wdata;
                m_mask  = win_dma ? d_sign_mask : c_sign_mask;
                m_lat   = m_we ? WR_LAT : RD_LAT;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rdval = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
            end
        end
        cyc++;
    end

    logic [31:0] addr_tab [5] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000};

    task automatic drive(input bit dma, input bit we, input logic [31:0] addr, wdata, input logic [3:0] mask);
        if (dma) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_sign_mask = mask; end
        else     begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; c_sign_mask = mask; end
    endtask

    task automatic do_access(input bit dma, input bit we, input logic [31:0] addr, wdata,
                             input logic [3:0] mask, input bit keep, output int gnt_cyc);
        bit got = 0;
        drive(dma, we, addr, wdata, mask);
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #2;
            if (dma ? d_gnt : c_gnt) got = 1;
        end
        check("gnt_seen", got, 1);
        gnt_cyc = cyc;
        if (!keep) begin
            if (dma) d_req = 0; else c_req = 0;
        end
    endtask

    task automatic wait_rvalid(input bit dma);
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #2;
            if (dma ? d_rvalid : c_rvalid) got = 1;
        end
        check("rvalid_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #2;
            if (!busy) got = 1;
        end
        check("idle_seen", got, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g1, g2, n, seen, ng;
        logic [3:0] seq, exp_seq;
        bit got;
        foreach (addr_tab[i]) begin
            logic [31:0] v;
            v = (addr_tab[i] == 32'h1004) ? 32'hDEADBEEF : $urandom;
            env_mem[addr_tab[i]] = v;
            ref_mem[addr_tab[i]] = v;
        end

        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Core load from 0x1004
        @(posedge clk); #2;
        do_access(0, 0, 32'h1004, 32'h0, 4'b0010, 0, g1);
        wait_rvalid(0);
        check("t1_c_rdata", c_rdata, 32'hDEADBEEF);
        check("t1_d_rdata", d_rdata, 32'h0);
        wait_idle();

        // DMA store: no rvalid, busy drops WR_LAT+1 cycles after the strobe cycle
        do_access(1, 1, 32'h1008, 32'h12345678, 4'b0100, 0, g1);
        n = 0; seen = 0; got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #2;
            n++;
            if (d_rvalid) seen++;
            if (!busy) got = 1;
        end
        check("t2_busy_fall", n, WR_LAT + 1);
        check("t2_no_rvalid", seen, 0);

        // Both requesting for four accesses
        drive(0, 0, 32'h1000, 32'h0, 4'b0001);
        drive(1, 0, 32'h1004, 32'h0, 4'b0011);
        ng = 0; seq = 0;
        for (int i = 0; i < 100 && ng < 4; i++) begin
            @(posedge clk); #2;
            if (c_gnt) begin seq[ng] = 1'b0; ng++; end
            else if (d_gnt) begin seq[ng] = 1'b1; ng++; end
        end
        c_req = 0; d_req = 0;
        check("t3_grants", ng, 4);
`ifdef DMEM_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        check("t3_order", seq, exp_seq);
        wait_idle();

        // Core store then load of the same address, request held throughout
        do_access(0, 1, 32'h1000, 32'h000000AA, 4'b0010, 1, g1);
        do_access(0, 0, 32'h1000, 32'h0, 4'b0010, 0, g2);
        check("t4_gap_ok", (g2 - g1) >= WR_LAT + 1, 1);
        wait_rvalid(0);
        check("t4_c_rdata", c_rdata, 32'h000000AA);
        wait_idle();

        // Core pulses req for one cycle while a DMA load is in progress
        do_access(1, 0, 32'h100C, 32'h0, 4'b0000, 0, g1);
        @(posedge clk); #2;
        drive(0, 0, 32'h1004, 32'h0, 4'b0000);
        @(posedge clk); #2;
        c_req = 0;
        seen = 0;
        for (int i = 0; i < RD_LAT + 6; i++) begin
            @(posedge clk); #2;
            if (c_gnt || mem_memread) seen++;
        end
        check("t6_no_grant", seen, 0);

        // Reset during WAIT of a core load, then the held request is reissued
        do_access(0, 0, 32'h1004, 32'h0, 4'b0010, 1, g1);
        @(posedge clk); #2;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_strobe", {mem_memread, mem_memwrite}, 0);
        check("t5_c_rvalid", c_rvalid, 0);
        check("t5_c_rdata", c_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #2;
            if (c_gnt) got = 1;
        end
        check("t5_regrant", got, 1);
        c_req = 0;
        wait_rvalid(0);
        check("t5_c_rdata_after", c_rdata, 32'hDEADBEEF);
        wait_idle();

        // Randomized traffic from both requesters
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (c_req && c_gnt) c_req = 0;
            else if (c_req && $urandom_range(0, 15) == 0) c_req = 0;
            if (!c_req && $urandom_range(0, 2) == 0)
                drive(0, 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 4)], $urandom, 4'($urandom_range(0, 15)));
            if (d_req && d_gnt) d_req = 0;
            else if (d_req && $urandom_range(0, 15) == 0) d_req = 0;
            if (!d_req && $urandom_range(0, 2) == 0)
                drive(1, 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 4)], $urandom, 4'($urandom_range(0, 15)));
        end
        c_req = 0; d_req = 0;
        repeat (12) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
